io_input_controller: RTL

Sequencing controller between the board's push-button, switches and the processor core. It debounces the active-low button and generates the processor's clock-enable tick: free-running in fast mode, or one tick per press in step mode. It also services the processor's input-instruction handshake by stalling the core until the user confirms a switch value with a button press. The button is shared between stepping and input confirmation, and the controller arbitrates between the two uses.

---
 rtl/io_input_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/io_input_controller.sv
// io_input_controller
//   Sits between the board push-button/switches and the processor core.
//   - Synchronizes and debounces the active-low push-button.
//   - Generates the processor clock-enable tick: free-running divider in fast
//     mode (Pause=1) or one tick per debounced press in step mode (Pause=0).
//   - Services the input-instruction handshake: while InReq is pending, the
//     core is stalled until the user presses (captures Sw) and releases the
//     button, after which InAck pulses for one cycle.
//   The button is shared: outside IDLE, presses belong to the handshake.
//
// Ports
//   Clock     system clock, all logic on posedge
//   Reset     asynchronous active-high reset
//   Botao     raw push-button, active-low, asynchronous
//   Sw        raw switch data, sampled only at capture
//   Pause     1 = fast free-run, 0 = step mode
//   InReq     input instruction pending (level, Clock-synchronous)
//   CpuEn     one-cycle processor advance enable (registered)
//   InAck     one-cycle handshake completion pulse (registered)
//   InData    {1'b1, captured Sw}, held between captures (registered)
//   Waiting   high while an input request is being serviced (registered)
//   BotaoDeb  debounced pressed state, 1 = pressed (registered)

module io_input_controller #(
    parameter int DEB_CYCLES = 32,
    parameter int FAST_DIV   = 6250000,
    parameter int DATA_W     = 13
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Botao,
    input  logic [DATA_W-1:0] Sw,
    input  logic              Pause,
    input  logic              InReq,
    output logic              CpuEn,
    output logic              InAck,
    output logic [DATA_W:0]   InData,
    output logic              Waiting,
    output logic              BotaoDeb
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DIV_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        ACK          = 2'd3
    } state_t;

    logic [1:0]       sync_r;
    logic             deb_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             press_edge_r;
    logic             release_edge_r;
    logic [DIV_W-1:0] div_r;
    state_t           state_r;
    logic             cpu_en_r;
    logic             in_ack_r;
    logic [DATA_W:0]  in_data_r;
    logic             waiting_r;

    logic             mismatch_s;
    logic             deb_flip_s;
    logic             press_now_s;
    logic             release_now_s;
    state_t           next_state_s;
    logic             capture_s;
    logic             tick_s;
    logic [DIV_W-1:0] div_next_s;

    // Debounce decisions: a flip happens on the last mismatching sample.
    // press_now_s/release_now_s mark the edge at which BotaoDeb changes, so
    // the registered CpuEn lines up with the registered PressEdge.
    assign mismatch_s    = (~sync_r[1]) != deb_r;
    assign deb_flip_s    = mismatch_s && (deb_cnt_r == DEB_LAST);
    assign press_now_s   = deb_flip_s && !deb_r;
    assign release_now_s = deb_flip_s && deb_r;

    // Button synchronizer and debouncer state, including the edge pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_r         <= 2'b11;
            deb_r          <= 1'b0;
            deb_cnt_r      <= '0;
            press_edge_r   <= 1'b0;
            release_edge_r <= 1'b0;
        end else begin
            sync_r         <= {sync_r[0], Botao};
            press_edge_r   <= press_now_s;
            release_edge_r <= release_now_s;
            if (deb_flip_s) begin
                deb_r     <= ~deb_r;
                deb_cnt_r <= '0;
            end else if (mismatch_s) begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end else begin
                deb_cnt_r <= '0;
            end
        end
    end

    // Next-state, capture and tick decisions; InReq in IDLE wins over a tick.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        tick_s       = 1'b0;
        div_next_s   = '0;
        case (state_r)
            IDLE: begin
                if (InReq) begin
                    next_state_s = WAIT_PRESS;
                end else if (Pause) begin
                    if (div_r == DIV_LAST) begin
                        tick_s     = 1'b1;
                        div_next_s = '0;
                    end else begin
                        tick_s     = 1'b0;
                        div_next_s = div_r + DIV_W'(1);
                    end
                end else begin
                    // Step mode: divider stays cleared so that a later rise of
                    // Pause always starts a full period.
                    tick_s = press_now_s;
                end
            end
            WAIT_PRESS: begin
                // Only a fresh press edge captures; a button already held on
                // entry must be released and pressed again.
                if (press_edge_r) begin
                    capture_s    = 1'b1;
                    next_state_s = WAIT_RELEASE;
                end else begin
                    next_state_s = WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (release_edge_r) begin
                    next_state_s = ACK;
                end else begin
                    next_state_s = WAIT_RELEASE;
                end
            end
            ACK: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state, divider and all registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            div_r     <= '0;
            cpu_en_r  <= 1'b0;
            in_ack_r  <= 1'b0;
            in_data_r <= '0;
            waiting_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            div_r     <= div_next_s;
            cpu_en_r  <= tick_s;
            in_ack_r  <= (next_state_s == ACK);
            waiting_r <= (next_state_s != IDLE);
            if (capture_s) begin
                in_data_r <= {1'b1, Sw};
            end else begin
                in_data_r <= in_data_r;
            end
        end
    end

    assign CpuEn    = cpu_en_r;
    assign InAck    = in_ack_r;
    assign InData   = in_data_r;
    assign Waiting  = waiting_r;
    assign BotaoDeb = deb_r;

endmodule
